// File: rtl/gdsp_pkg.sv
// Shared types and constants for the GDSP noise-sweep controller.
package gdsp_pkg;

  localparam int unsigned NOISE_W = 8;
  localparam int unsigned LEVEL_W = 2;

  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } sweep_state_t;

  // Noise magnitude per sweep level, index 0 is the quietest
  localparam logic [NOISE_W-1:0] NOISE_LUT [4] = '{8'd16, 8'd32, 8'd64, 8'd128};

  function automatic logic [NOISE_W-1:0] noise_of(input logic [LEVEL_W-1:0] lvl);
    return NOISE_LUT[lvl];
  endfunction

endpackage

// File: rtl/gdsp_sweep_ctrl_if.sv
// Button, channel-strobe and capture-port bundle of the sweep controller.
interface gdsp_sweep_ctrl_if #(
  parameter int unsigned CAP_LEN = 256
) ();
  import gdsp_pkg::*;

  localparam int unsigned AW = (CAP_LEN > 1) ? $clog2(CAP_LEN) : 1;

  logic               btn_sync;
  logic               auto_mode;
  logic               rx_valid;
  logic [NOISE_W-1:0] noise_mag;
  logic [LEVEL_W-1:0] level_idx;
  logic               cap_en;
  logic [AW-1:0]      cap_addr;
  logic               cap_done;
  logic               busy;

  modport master (
    input  btn_sync, auto_mode, rx_valid,
    output noise_mag, level_idx, cap_en, cap_addr, cap_done, busy
  );

  modport slave (
    output btn_sync, auto_mode, rx_valid,
    input  noise_mag, level_idx, cap_en, cap_addr, cap_done, busy
  );

endinterface

// File: rtl/gdsp_sweep_ctrl_btn_debounce.sv
// Button debouncer: level follows the input only after it has been stable
// for DEBOUNCE_CYC cycles; fall pulses once on each debounced 1->0 edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 270000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic level,
  output logic fall
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the input agrees with the level restarts the count
  always_comb begin
    level_d = level_q;
    fall_d  = 1'b0;
    cnt_d   = '0;
    if (btn_in != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        level_d = btn_in;
        fall_d  = ~btn_in;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/gdsp_sweep_ctrl.sv
// Noise-level sweep controller: steps the AWGN magnitude, blanks while the
// channel settles, captures one frame per level, then holds for the operator.
module gdsp_sweep_ctrl
  import gdsp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 270000,
  parameter int unsigned SETTLE_CYC   = 64,
  parameter int unsigned CAP_LEN      = 256,
  parameter int unsigned DWELL_CYC    = 27000000
) (
  input  logic                clk,
  input  logic                rst_n,
  gdsp_sweep_ctrl_if.master   bus
);

  localparam int unsigned AW = (CAP_LEN > 1) ? $clog2(CAP_LEN) : 1;
  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned DW = $clog2(DWELL_CYC + 1);

  sweep_state_t       state_q, state_d;
  logic [SW-1:0]      settle_cnt_q, settle_cnt_d;
  logic [DW-1:0]      dwell_q, dwell_d;
  logic [AW-1:0]      cap_addr_q, cap_addr_d;
  logic               cap_done_q, cap_done_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [NOISE_W-1:0] noise_q, noise_d;
  logic               pend_q, pend_d;
  logic               auto_q, auto_d;
  logic               busy_q, busy_d;
  logic               cap_en_c;
  logic               step_c;
  logic               press_c;
  logic               btn_level;
  logic               btn_fall;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (bus.btn_sync),
    .level  (btn_level),
    .fall   (btn_fall)
  );

  assign press_c = btn_fall & ~btn_level;

  // Next-state, capture addressing and level stepping
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    dwell_d      = dwell_q;
    cap_addr_d   = cap_addr_q;
    cap_done_d   = 1'b0;
    level_d      = level_q;
    noise_d      = noise_q;
    pend_d       = pend_q;
    auto_d       = auto_q;
    cap_en_c     = 1'b0;
    step_c       = 1'b0;

    case (state_q)
      SETTLE: begin
        if (press_c) pend_d = 1'b1;
        if (settle_cnt_q == SW'(SETTLE_CYC - 1)) begin
          state_d      = CAPTURE;
          settle_cnt_d = '0;
          cap_addr_d   = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end

      CAPTURE: begin
        if (press_c) pend_d = 1'b1;
        cap_en_c = bus.rx_valid;
        if (cap_en_c) begin
          if (cap_addr_q == AW'(CAP_LEN - 1)) begin
            cap_addr_d = '0;
            cap_done_d = 1'b1;
            dwell_d    = '0;
            state_d    = HOLD;
          end else begin
            cap_addr_d = cap_addr_q + AW'(1);
          end
        end
      end

      HOLD: begin
        auto_d = bus.auto_mode;
        if (bus.auto_mode) begin
          // A press queued during the frame has no meaning in timed sweep
          pend_d = 1'b0;
          if (bus.auto_mode != auto_q) begin
            dwell_d = '0;
          end else if (dwell_q == DW'(DWELL_CYC - 1)) begin
            step_c = 1'b1;
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end else begin
          dwell_d = '0;
          if (press_c || pend_q) step_c = 1'b1;
        end
      end

      default: state_d = SETTLE;
    endcase

    // The only path that changes the noise level: HOLD -> SETTLE
    if (step_c) begin
      level_d      = level_q + LEVEL_W'(1);
      noise_d      = noise_of(level_d);
      state_d      = SETTLE;
      settle_cnt_d = '0;
      dwell_d      = '0;
      pend_d       = 1'b0;
    end
  end

  assign busy_d = (state_d != HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SETTLE;
      settle_cnt_q <= '0;
      dwell_q      <= '0;
      cap_addr_q   <= '0;
      cap_done_q   <= 1'b0;
      level_q      <= '0;
      noise_q      <= NOISE_LUT[0];
      pend_q       <= 1'b0;
      auto_q       <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      dwell_q      <= dwell_d;
      cap_addr_q   <= cap_addr_d;
      cap_done_q   <= cap_done_d;
      level_q      <= level_d;
      noise_q      <= noise_d;
      pend_q       <= pend_d;
      auto_q       <= auto_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.noise_mag = noise_q;
  assign bus.level_idx = level_q;
  assign bus.cap_en    = cap_en_c;
  assign bus.cap_addr  = cap_addr_q;
  assign bus.cap_done  = cap_done_q;
  assign bus.busy      = busy_q;

endmodule
